// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array for the fifo: one synchronous write port, one
// asynchronous read port, all entries cleared on reset.
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes.
// Depth need not be a power of two; pointers wrap by explicit compare.
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_valid,
    input  logic             r_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr, do_rd;
    logic [WIDTH-1:0] rdata;

    // Flags come from the registered count only, so acceptance never
    // depends combinationally on the opposite handshake.
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign do_wr      = w_valid && !fifo_full;
    assign do_rd      = r_ready && !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (do_wr),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign data_out = fifo_empty ? '0 : rdata;

endmodule

// File: tb/tb_fifo.sv
// Randomized + directed bench for fifo (WIDTH=32, DEPTH=3) against a queue model.
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic             clk;
    logic             reset;
    logic             w_valid;
    logic             r_ready;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH-1:0] q[$];

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_valid    (w_valid),
        .r_ready    (r_ready),
        .data_in    (data_in),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference: a plain queue; a push is allowed only if there was room
    // before the edge, a pop only if there was data before the edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
        end else begin
            automatic bit wr = w_valid && (q.size() < DEPTH);
            automatic bit rd = r_ready && (q.size() > 0);
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(data_in);
        end
    end

    always @(negedge clk) begin
        check("empty", {31'b0, fifo_empty}, {31'b0, q.size() == 0});
        check("full",  {31'b0, fifo_full},  {31'b0, q.size() == DEPTH});
        check("data_out", data_out, (q.size() == 0) ? '0 : q[0]);
    end

    task automatic step(input logic wv, input logic rr, input logic [WIDTH-1:0] d);
        @(negedge clk);
        #1;
        w_valid = wv;
        r_ready = rr;
        data_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        reset   = 1'b0;
        w_valid = 1'b0;
        r_ready = 1'b0;
        data_in = '0;
        #12;
        check("rst_empty", {31'b0, fifo_empty}, 32'd1);
        check("rst_full",  {31'b0, fifo_full},  32'd0);
        check("rst_data",  data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Overfill: only 0,1,2 fit
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b0, 1'b0, '0);
        check("ovf_full", {31'b0, fifo_full}, 32'd1);
        check("ovf_head", data_out, 32'd0);

        // Drain: 0,1,2 then an ignored pop
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, '0);
            if (i < 3) check("drain_data", data_out, 32'(i));
            else       check("drain_empty", {31'b0, fifo_empty}, 32'd1);
        end
        step(1'b0, 1'b0, '0);
        check("drain_done", {31'b0, fifo_empty}, 32'd1);

        // Wrap: write-2/read-2 rounds push pointers around repeatedly
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b0, 32'h10 + 32'(2 * r));
            step(1'b1, 1'b0, 32'h11 + 32'(2 * r));
            step(1'b0, 1'b1, '0);
            check("wrap_head", data_out, 32'h10 + 32'(2 * r));
            step(1'b0, 1'b1, '0);
            check("wrap_head2", data_out, 32'h11 + 32'(2 * r));
        end
        step(1'b0, 1'b0, '0);

        // Simultaneous read+write
        step(1'b1, 1'b0, 32'h50);
        step(1'b1, 1'b0, 32'h51);
        step(1'b1, 1'b1, 32'hAA);
        step(1'b0, 1'b0, '0);
        check("sim_head", data_out, 32'h51);
        check("sim_notfull", {31'b0, fifo_full}, 32'd0);
        step(1'b1, 1'b0, 32'h52);
        step(1'b1, 1'b1, 32'hBB);
        step(1'b0, 1'b0, '0);
        check("simf_head", data_out, 32'hAA);
        check("simf_notfull", {31'b0, fifo_full}, 32'd0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        check("simf_tail", data_out, 32'h52);
        step(1'b0, 1'b0, '0);

        // Async reset between edges with 2 entries held
        step(1'b1, 1'b0, 32'h60);
        step(1'b1, 1'b0, 32'h61);
        step(1'b0, 1'b0, '0);
        #2;
        reset = 1'b0;
        #1;
        check("arst_empty", {31'b0, fifo_empty}, 32'd1);
        check("arst_full",  {31'b0, fifo_full},  32'd0);
        check("arst_data",  data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 32'h70);
        step(1'b0, 1'b0, '0);
        check("arst_fresh", data_out, 32'h70);
        step(1'b0, 1'b1, '0);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        step(1'b0, 1'b0, '0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
